fpa_rr_scheduler: RTL and testbench
===================================

Name: fpa_rr_scheduler

Overview:
Shares one combinational fpa adder datapath between NUM_REQ requesters using round-robin arbitration.
- Each requester presents operand pairs on a valid/ready handshake.
- The block registers the granted operands onto the fpa inputs, captures the fpa sum one cycle later, and returns it on a single tagged result channel.
- It sits between the requester cores and the shared fpa instance; the fpa itself is instantiated outside this block.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_W, 2, width of result tag; must equal clog2(NUM_REQ)

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
req_valid  input  NUM_REQ  per-requester operand valid
req_ready  output  NUM_REQ  per-requester accept strobe
req_a  input  NUM_REQ*32  operand A, requester i at bits [32*i+31:32*i]
req_b  input  NUM_REQ*32  operand B, same packing
fpa_a  output  32  registered operand A to shared fpa
fpa_b  output  32  registered operand B to shared fpa
fpa_result  input  32  combinational fpa sum of fpa_a, fpa_b
res_valid  output  1  result available
res_ready  input  1  result consumer accepts
res_data  output  32  registered sum
res_id  output  ID_W  index of requester that issued the op
busy  output  1  high in CALC or DONE

Behaviour:
- Reset (rst high, async): state=IDLE; rr_ptr=0; fpa_a, fpa_b, res_data=0; res_id=0; res_valid=0; busy=0; req_ready=0.
- Any in-flight op is discarded on reset; no result is emitted after reset release.
- States:
  - IDLE: no op held.
  - CALC: operands on fpa_a/fpa_b, sum settling.
  - DONE: result held on res_*.
- Accept opportunity: a cycle with state==IDLE, or state==DONE with res_ready==1.
- Grant: in an accept opportunity with any req_valid set, grant g = first set req_valid index searching rr_ptr, rr_ptr+1, … modulo NUM_REQ.
  - req_ready is combinational: one-hot at bit g only in that cycle; all zero otherwise.
  - Transfer occurs when req_valid[g] & req_ready[g].
  - On the transfer edge: fpa_a<=req_a[g]; fpa_b<=req_b[g]; tag<=g; rr_ptr<=(g+1) mod NUM_REQ; state->CALC.
- CALC: lasts exactly 1 cycle. On its closing edge: res_data<=fpa_result; res_id<=tag; state->DONE.
- DONE: res_valid=1; res_data and res_id stable until handshake.
  - res_valid & res_ready with a pending request: grant in the same cycle; state->CALC.
  - res_valid & res_ready with no request: state->IDLE.
  - res_ready low: stay in DONE; req_ready stays 0.
- Timing:
  - Latency: accept edge T → res_valid high in cycle T+2.
  - Peak throughput: one op per 2 cycles.
- fpa_a/fpa_b hold their last values in IDLE and DONE; they change only on a transfer edge.
- rr_ptr changes only on a grant. Requesters without valid are skipped with no cycle penalty.
- Simultaneous valids: exactly one grant per accept opportunity; the others wait.
- Requesters must hold req_valid and operands stable until req_ready. Withdrawal before grant is legal and simply loses arbitration.
- res_valid=0 in IDLE and CALC; busy = (state!=IDLE).
- No other arithmetic is performed here; NaN/denormal handling is entirely the fpa's.

Test Plan:
1. Req0 valid, A=0x3F800000 (1.0), B=0x40000000 (2.0), res_ready=1 → req_ready=4'b0001 in cycle 0; res_valid in cycle 2 with res_data=0x40400000 (3.0), res_id=0; then IDLE.
2. All 4 req_valid held high, res_ready=1, distinct operands → grants in order 0,1,2,3,0, one every 2 cycles; res_id sequence 0,1,2,3,0 with matching sums.
3. After a grant to 2, only req0 and req2 valid → next grant 0, not 2; rr_ptr=1 afterwards.
4. Result ready, res_ready held low 5 cycles → res_valid=1 and res_data/res_id unchanged throughout; req_ready=0 throughout; grant issues in the cycle res_ready rises.
5. rst asserted asynchronously mid-CALC (between clock edges) → all outputs 0 immediately; after release, no res_valid until a new accept; first grant goes to lowest valid index.
6. A=0x40A00000 (5.0), B=0xC0A00000 (-5.0) from req3 → res_data=0x00000000, res_id=3, with fpa_a/fpa_b held at those values through DONE.

Source files
------------

// File: rtl/fpa_rr_scheduler.sv
// ---------------------------------------------------------------------------
// fpa_rr_scheduler
//
// Shares one combinational floating-point adder (instantiated outside this
// block) between NUM_REQ requesters. Requesters are served in round-robin
// order. Each granted operand pair is registered onto fpa_a/fpa_b. The
// adder's sum is captured one cycle later and presented on a single tagged
// result channel.
//
// Operation timeline:
//   accept edge -> CALC (operands settle through the adder)
//               -> DONE (result held until the consumer takes it).
// A new grant can be issued in the same cycle that a DONE result is consumed.
// This allows a peak throughput of one operation every two cycles.
//
// Parameters:
//   NUM_REQ  number of requesters (2..8)
//   ID_W     result tag width, must equal $clog2(NUM_REQ)
//
// Ports:
//   clk, rst      clock (rising edge), asynchronous active-high reset
//   req_valid     per-requester operand valid
//   req_ready     per-requester accept strobe (combinational, one-hot)
//   req_a, req_b  packed operands, requester i at [32*i +: 32]
//   fpa_a, fpa_b  registered operands driven to the shared adder
//   fpa_result    combinational adder sum of fpa_a + fpa_b
//   res_valid     result available
//   res_ready     result consumer accepts
//   res_data      registered sum
//   res_id        index of the requester that issued the operation
//   busy          high while an operation is in CALC or DONE
// ---------------------------------------------------------------------------
module fpa_rr_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*32-1:0] req_a,
  input  logic [NUM_REQ*32-1:0] req_b,
  output logic [31:0]           fpa_a,
  output logic [31:0]           fpa_b,
  input  logic [31:0]           fpa_result,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [31:0]           res_data,
  output logic [ID_W-1:0]       res_id,
  output logic                  busy
);

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]     tag_q, tag_d;
  logic [DATA_W-1:0]   fpa_a_q, fpa_a_d;
  logic [DATA_W-1:0]   fpa_b_q, fpa_b_d;
  logic [DATA_W-1:0]   res_data_q, res_data_d;
  logic [ID_W-1:0]     res_id_q, res_id_d;

  logic                accept_opp;
  logic                grant_found;
  logic [ID_W-1:0]     grant_idx;
  logic                xfer;
  logic [DATA_W-1:0]   op_a, op_b;

  // Rotating-priority search. Scan rr_ptr, rr_ptr+1, ... (mod NUM_REQ).
  // Return {found, index} for the first set valid bit.
  function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] vld,
                                            input logic [ID_W-1:0]    ptr);
    logic            found;
    logic [ID_W-1:0] idx;
    int              pos;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = int'(ptr) + k;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      if (!found && vld[pos]) begin
        found = 1'b1;
        idx   = ID_W'(pos);
      end
    end
    return {found, idx};
  endfunction

  // Compute (g + 1) mod NUM_REQ.
  // NUM_REQ need not be a power of two, so wrap explicitly.
  function automatic logic [ID_W-1:0] ptr_after(input logic [ID_W-1:0] g);
    if (int'(g) == NUM_REQ - 1) return '0;
    return g + ID_W'(1);
  endfunction

  // Arbitration and the combinational accept strobe.
  // req_ready is forced low while reset is asserted.
  always_comb begin
    accept_opp = !rst && ((state_q == S_IDLE) ||
                          ((state_q == S_DONE) && res_ready));
    {grant_found, grant_idx} = rr_pick(req_valid, rr_ptr_q);
    req_ready = '0;
    if (accept_opp && grant_found) req_ready[grant_idx] = 1'b1;
    xfer = |(req_valid & req_ready);
  end

  // Operand select for the granted requester
  always_comb begin
    op_a = '0;
    op_b = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (int'(grant_idx) == k) begin
        op_a = req_a[k*DATA_W +: DATA_W];
        op_b = req_b[k*DATA_W +: DATA_W];
      end
    end
  end

  // Next-state logic and datapath register enables
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    tag_d      = tag_q;
    fpa_a_d    = fpa_a_q;
    fpa_b_d    = fpa_b_q;
    res_data_d = res_data_q;
    res_id_d   = res_id_q;

    case (state_q)
      S_IDLE: begin
        if (xfer) state_d = S_CALC;
      end
      S_CALC: begin
        // Operands have had a full cycle to propagate through the adder
        res_data_d = fpa_result;
        res_id_d   = tag_q;
        state_d    = S_DONE;
      end
      S_DONE: begin
        if (res_ready) state_d = xfer ? S_CALC : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Operands, tag and pointer move only on a transfer edge
    if (xfer) begin
      fpa_a_d  = op_a;
      fpa_b_d  = op_b;
      tag_d    = grant_idx;
      rr_ptr_d = ptr_after(grant_idx);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= '0;
      tag_q      <= '0;
      fpa_a_q    <= '0;
      fpa_b_q    <= '0;
      res_data_q <= '0;
      res_id_q   <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      tag_q      <= tag_d;
      fpa_a_q    <= fpa_a_d;
      fpa_b_q    <= fpa_b_d;
      res_data_q <= res_data_d;
      res_id_q   <= res_id_d;
    end
  end

  assign fpa_a     = fpa_a_q;
  assign fpa_b     = fpa_b_q;
  assign res_data  = res_data_q;
  assign res_id    = res_id_q;
  assign res_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_fpa_rr_scheduler.sv
// ---------------------------------------------------------------------------
// Directed testbench for fpa_rr_scheduler (NUM_REQ=4).
// The shared adder is stood in for by a lookup of hand-computed IEEE-754
// sums for the operand pairs used below.
// Inputs are driven 1 time unit after the rising edge.
// Outputs are sampled 2 time units later.
// ---------------------------------------------------------------------------
module tb_fpa_rr_scheduler;

  logic         clk;
  logic         rst;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [127:0] req_a;
  logic [127:0] req_b;
  logic [31:0]  fpa_a;
  logic [31:0]  fpa_b;
  logic [31:0]  fpa_result;
  logic         res_valid;
  logic         res_ready;
  logic [31:0]  res_data;
  logic [1:0]   res_id;
  logic         busy;

  int vectors;
  int miscompares;

  logic [31:0] opa [4];
  logic [31:0] opb [4];
  logic [31:0] sum [4];

  fpa_rr_scheduler #(.NUM_REQ(4), .ID_W(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .fpa_a      (fpa_a),
    .fpa_b      (fpa_b),
    .fpa_result (fpa_result),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_id     (res_id),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in adder: hand-computed single-precision sums
  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h3F800000, 32'h40000000}: return 32'h40400000; // 1+2=3
      {32'h40000000, 32'h40000000}: return 32'h40800000; // 2+2=4
      {32'h3F800000, 32'h3F800000}: return 32'h40000000; // 1+1=2
      {32'h40800000, 32'h3F800000}: return 32'h40A00000; // 4+1=5
      {32'h3F000000, 32'h3F000000}: return 32'h3F800000; // .5+.5=1
      {32'h40A00000, 32'hC0A00000}: return 32'h00000000; // 5-5=0
      default:                      return 32'h7FC00000;
    endcase
  endfunction

  always_comb fpa_result = fadd(fpa_a, fpa_b);

  task automatic go();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    go();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    go();
    #2;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy got %b want 0", busy); end
    vectors++; if (res_valid !== 1'b0) begin miscompares++; $display("FAIL rst_res_valid got %b want 0", res_valid); end
    vectors++; if (req_ready !== 4'b0000) begin miscompares++; $display("FAIL rst_req_ready got %b want 0000", req_ready); end
    vectors++; if ({fpa_a, fpa_b, res_data} !== 96'h0) begin miscompares++; $display("FAIL rst_data got %h %h %h want 0", fpa_a, fpa_b, res_data); end
    vectors++; if (res_id !== 2'd0) begin miscompares++; $display("FAIL rst_res_id got %0d want 0", res_id); end
    go();
    rst = 1'b0;
  endtask

  task automatic test_single();
    set_op(0, opa[0], opb[0]);
    req_valid = 4'b0001;
    res_ready = 1'b1;
    #2;
    vectors++; if (req_ready !== 4'b0001) begin miscompares++; $display("FAIL t1_req_ready got %b want 0001", req_ready); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL t1_busy_idle got %b want 0", busy); end
    go();
    req_valid = 4'b0000;
    #2;
    vectors++; if (busy !== 1'b1 || res_valid !== 1'b0) begin miscompares++; $display("FAIL t1_calc busy/res_valid got %b/%b want 1/0", busy, res_valid); end
    vectors++; if (fpa_a !== 32'h3F800000 || fpa_b !== 32'h40000000) begin miscompares++; $display("FAIL t1_fpa_ops got %h %h want 3f800000 40000000", fpa_a, fpa_b); end
    go();
    #2;
    vectors++; if (res_valid !== 1'b1) begin miscompares++; $display("FAIL t1_res_valid got %b want 1", res_valid); end
    vectors++; if (res_data !== 32'h40400000) begin miscompares++; $display("FAIL t1_res_data got %h want 40400000", res_data); end
    vectors++; if (res_id !== 2'd0) begin miscompares++; $display("FAIL t1_res_id got %0d want 0", res_id); end
    go();
    #2;
    vectors++; if (busy !== 1'b0 || res_valid !== 1'b0) begin miscompares++; $display("FAIL t1_back_idle busy/res_valid got %b/%b want 0/0", busy, res_valid); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] er;
    logic [1:0] eid;
    reset_pulse();
    for (int i = 0; i < 4; i++) set_op(i, opa[i], opb[i]);
    req_valid = 4'b1111;
    res_ready = 1'b1;
    #2;
    for (int k = 0; k < 5; k++) begin
      er = 4'b0001 << (k % 4);
      vectors++; if (req_ready !== er) begin miscompares++; $display("FAIL t2_grant_%0d got %b want %b", k, req_ready, er); end
      if (k > 0) begin
        eid = 2'((k - 1) % 4);
        vectors++; if (res_valid !== 1'b1 || res_id !== eid) begin miscompares++; $display("FAIL t2_res_id_%0d got v=%b id=%0d want v=1 id=%0d", k, res_valid, res_id, eid); end
        vectors++; if (res_data !== sum[(k - 1) % 4]) begin miscompares++; $display("FAIL t2_res_data_%0d got %h want %h", k, res_data, sum[(k - 1) % 4]); end
      end
      go();
      #2;
      vectors++; if (res_valid !== 1'b0 || busy !== 1'b1 || fpa_a !== opa[k % 4]) begin miscompares++; $display("FAIL t2_calc_%0d got v=%b busy=%b a=%h want v=0 busy=1 a=%h", k, res_valid, busy, fpa_a, opa[k % 4]); end
      if (k == 4) req_valid = 4'b0000;
      go();
      #2;
    end
    vectors++; if (res_valid !== 1'b1 || res_id !== 2'd0 || res_data !== sum[0]) begin miscompares++; $display("FAIL t2_last got v=%b id=%0d d=%h want v=1 id=0 d=%h", res_valid, res_id, res_data, sum[0]); end
    vectors++; if (req_ready !== 4'b0000) begin miscompares++; $display("FAIL t2_last_ready got %b want 0000", req_ready); end
    go();
    #2;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL t2_idle got busy=%b want 0", busy); end
  endtask

  // rr_ptr is 1 on entry (last grant went to 0)
  task automatic test_rr_skip();
    req_valid = 4'b0100;
    #2;
    vectors++; if (req_ready !== 4'b0100) begin miscompares++; $display("FAIL t3_grant2 got %b want 0100", req_ready); end
    go();
    req_valid = 4'b0101;
    #2;
    go();
    #2;
    vectors++; if (res_id !== 2'd2 || res_data !== sum[2]) begin miscompares++; $display("FAIL t3_res2 got id=%0d d=%h want id=2 d=%h", res_id, res_data, sum[2]); end
    vectors++; if (req_ready !== 4'b0001) begin miscompares++; $display("FAIL t3_grant0 got %b want 0001", req_ready); end
    go();
    req_valid = 4'b1101;
    #2;
    go();
    #2;
    vectors++; if (res_id !== 2'd0) begin miscompares++; $display("FAIL t3_res0 got id=%0d want 0", res_id); end
    // pointer now 1: among {0,2,3} requester 2 wins
    vectors++; if (req_ready !== 4'b0100) begin miscompares++; $display("FAIL t3_ptr_after got %b want 0100", req_ready); end
    go();
    req_valid = 4'b0000;
    #2;
    go();
    #2;
    vectors++; if (res_id !== 2'd2 || res_valid !== 1'b1) begin miscompares++; $display("FAIL t3_res2b got v=%b id=%0d want v=1 id=2", res_valid, res_id); end
    go();
    #2;
  endtask

  task automatic test_backpressure();
    reset_pulse();
    set_op(1, 32'h3F000000, 32'h3F000000);
    req_valid = 4'b0010;
    res_ready = 1'b0;
    #2;
    vectors++; if (req_ready !== 4'b0010) begin miscompares++; $display("FAIL t4_grant1 got %b want 0010", req_ready); end
    go();
    req_valid = 4'b1000;
    #2;
    for (int i = 0; i < 5; i++) begin
      go();
      #2;
      vectors++; if (res_valid !== 1'b1 || res_data !== 32'h3F800000 || res_id !== 2'd1) begin miscompares++; $display("FAIL t4_hold_%0d got v=%b d=%h id=%0d want v=1 d=3f800000 id=1", i, res_valid, res_data, res_id); end
      vectors++; if (req_ready !== 4'b0000) begin miscompares++; $display("FAIL t4_stall_ready_%0d got %b want 0000", i, req_ready); end
    end
    go();
    res_ready = 1'b1;
    #2;
    vectors++; if (req_ready !== 4'b1000 || res_valid !== 1'b1) begin miscompares++; $display("FAIL t4_release got ready=%b v=%b want 1000 v=1", req_ready, res_valid); end
    go();
    req_valid = 4'b0000;
    #2;
    vectors++; if (fpa_a !== 32'h40800000 || fpa_b !== 32'h3F800000) begin miscompares++; $display("FAIL t4_ops3 got %h %h want 40800000 3f800000", fpa_a, fpa_b); end
    go();
    #2;
    vectors++; if (res_id !== 2'd3 || res_data !== 32'h40A00000) begin miscompares++; $display("FAIL t4_res3 got id=%0d d=%h want id=3 d=40a00000", res_id, res_data); end
    go();
    #2;
  endtask

  // rr_ptr is 0 on entry
  task automatic test_async_reset();
    req_valid = 4'b0100;
    #2;
    vectors++; if (req_ready !== 4'b0100) begin miscompares++; $display("FAIL t5_grant2 got %b want 0100", req_ready); end
    go();
    req_valid = 4'b0000;
    #2;
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL t5_calc busy got %b want 1", busy); end
    #1;
    rst = 1'b1;
    #1;
    vectors++; if (busy !== 1'b0 || res_valid !== 1'b0) begin miscompares++; $display("FAIL t5_async_ctl got busy=%b v=%b want 0/0", busy, res_valid); end
    vectors++; if ({fpa_a, fpa_b, res_data} !== 96'h0 || res_id !== 2'd0) begin miscompares++; $display("FAIL t5_async_data got %h %h %h id=%0d want 0", fpa_a, fpa_b, res_data, res_id); end
    req_valid = 4'b1010;
    #1;
    vectors++; if (req_ready !== 4'b0000) begin miscompares++; $display("FAIL t5_ready_in_rst got %b want 0000", req_ready); end
    go();
    go();
    rst = 1'b0;
    req_valid = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      #2;
      vectors++; if (res_valid !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL t5_quiet_%0d got v=%b busy=%b want 0/0", i, res_valid, busy); end
      go();
    end
    req_valid = 4'b1010;
    #2;
    vectors++; if (req_ready !== 4'b0010) begin miscompares++; $display("FAIL t5_first_grant got %b want 0010", req_ready); end
    go();
    req_valid = 4'b0000;
    go();
    #2;
    vectors++; if (res_id !== 2'd1 || res_data !== 32'h3F800000) begin miscompares++; $display("FAIL t5_res got id=%0d d=%h want id=1 d=3f800000", res_id, res_data); end
    go();
    #2;
  endtask

  // rr_ptr is 2 on entry
  task automatic test_cancel();
    set_op(3, 32'h40A00000, 32'hC0A00000);
    req_valid = 4'b1000;
    res_ready = 1'b1;
    #2;
    vectors++; if (req_ready !== 4'b1000) begin miscompares++; $display("FAIL t6_grant3 got %b want 1000", req_ready); end
    go();
    req_valid = 4'b0000;
    res_ready = 1'b0;
    #2;
    vectors++; if (fpa_a !== 32'h40A00000 || fpa_b !== 32'hC0A00000) begin miscompares++; $display("FAIL t6_ops got %h %h want 40a00000 c0a00000", fpa_a, fpa_b); end
    go();
    #2;
    vectors++; if (res_valid !== 1'b1 || res_data !== 32'h00000000 || res_id !== 2'd3) begin miscompares++; $display("FAIL t6_res got v=%b d=%h id=%0d want v=1 d=00000000 id=3", res_valid, res_data, res_id); end
    go();
    res_ready = 1'b1;
    #2;
    vectors++; if (fpa_a !== 32'h40A00000 || fpa_b !== 32'hC0A00000 || res_valid !== 1'b1) begin miscompares++; $display("FAIL t6_ops_done got %h %h v=%b want 40a00000 c0a00000 v=1", fpa_a, fpa_b, res_valid); end
    go();
    #2;
    vectors++; if (busy !== 1'b0 || fpa_a !== 32'h40A00000 || fpa_b !== 32'hC0A00000) begin miscompares++; $display("FAIL t6_ops_idle got busy=%b %h %h want 0 40a00000 c0a00000", busy, fpa_a, fpa_b); end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    req_valid   = 4'b0000;
    res_ready   = 1'b0;
    req_a       = '0;
    req_b       = '0;
    opa[0] = 32'h3F800000; opb[0] = 32'h40000000; sum[0] = 32'h40400000;
    opa[1] = 32'h40000000; opb[1] = 32'h40000000; sum[1] = 32'h40800000;
    opa[2] = 32'h3F800000; opb[2] = 32'h3F800000; sum[2] = 32'h40000000;
    opa[3] = 32'h40800000; opb[3] = 32'h3F800000; sum[3] = 32'h40A00000;

    test_reset();
    test_single();
    test_back_to_back();
    test_rr_skip();
    test_backpressure();
    test_async_reset();
    test_cancel();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
